dtc_vote_accum: RTL
===================

DTC_VOTE_ACCUM -- requirements
Module: dtc_vote_accum

Interface
REQ-001 The block SHALL have parameter WINDOW, default 16: the number of classifier results per vote window; legal range 2..255.
REQ-002 The block SHALL have parameter CNT_W, default 5: the width of each vote counter; it SHALL equal clog2(WINDOW+1).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_class carries a classifier result.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a result this cycle.
REQ-008 The block SHALL have port in_class, input, 3 bits: the 3-bit class code from the upstream decision-tree classifier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the window verdict is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the verdict.
REQ-011 The block SHALL have port out_class, output, 3 bits: the majority class of the window.
REQ-012 The block SHALL have port out_count, output, CNT_W bits: the vote count of out_class.
REQ-013 The block SHALL have port out_tie, output, 1 bit: at least one other class holds a count equal to out_count.

Function
REQ-014 The block SHALL keep eight vote counters cnt[0..7] of CNT_W bits each, plus a sample counter smp of CNT_W bits.
REQ-015 The block SHALL implement an FSM with states ACCUM, SCAN and HOLD.
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 An input handshake occurs when in_valid=1 and in_ready=1 at a rising edge; on each handshake cnt[in_class] SHALL increment by 1 and smp SHALL increment by 1.
REQ-018 When in_valid=0 in ACCUM, no counter SHALL change.
REQ-019 On the handshake where smp equals WINDOW-1, the FSM SHALL move to SCAN and set the scan index to 0.
REQ-020 The counters SHALL never wrap, because WINDOW fits in CNT_W.
REQ-021 In SCAN, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-022 SCAN SHALL examine one class per cycle, index 0 to 7 ascending, taking 8 cycles.
REQ-023 During SCAN, the running best SHALL update only on a strictly greater count, so the lowest class index wins ties.
REQ-024 During SCAN, a tie flag SHALL be set when a later count equals the running best.
REQ-025 During SCAN, the tie flag SHALL be cleared when a later count exceeds the running best.
REQ-026 After index 7, the FSM SHALL enter HOLD, so out_valid rises 9 cycles after the edge that accepted the final sample.
REQ-027 In HOLD, out_valid SHALL be 1 and in_ready SHALL be 0.
REQ-028 In HOLD, out_class, out_count and out_tie SHALL be stable until handshake.
REQ-029 When out_valid=1 and out_ready=1 at an edge, all cnt, smp and scan registers SHALL clear and the FSM SHALL return to ACCUM.
REQ-030 The next input SHALL be acceptable in the cycle after the output handshake; there SHALL be no overlap between windows.
REQ-031 If out_ready is held high before HOLD is entered, the output handshake SHALL complete on the first HOLD cycle.
REQ-032 in_valid asserted during SCAN or HOLD SHALL have no effect, and upstream SHALL hold its data until in_ready returns.
REQ-033 in_class SHALL be sampled only on a handshake edge.

Reset
REQ-034 On rst=1, asynchronously, the FSM SHALL go to ACCUM and all cnt, smp, scan index, best and tie registers SHALL go to 0.
REQ-035 On rst=1, out_valid SHALL be 0, out_class SHALL be 3'b000, out_count SHALL be 0, out_tie SHALL be 0 and in_ready SHALL be 0.
REQ-036 After rst deasserts, in_ready SHALL be 1 from the first clock edge.
REQ-037 Reset asserted during ACCUM, SCAN or HOLD SHALL discard the partial window, with no verdict emitted for it.
REQ-038 The first window after reset SHALL count only post-reset samples.

Verification
REQ-039 WINDOW=16; 16 back-to-back samples of class 3'b101 -> out_valid rises 9 cycles after the last accept; out_class=5, out_count=16, out_tie=0.
REQ-040 8 samples of class 6 then 8 of class 2 -> out_class=2, out_count=8, out_tie=1.
REQ-041 Counts class1=5, class4=6, class7=5, with in_valid gaps of random length -> out_class=4, out_count=6, out_tie=0; counts unaffected by the gaps.
REQ-042 out_ready=0 for 20 cycles in HOLD, with in_valid=1 throughout -> outputs stable, in_ready=0, no count change; on out_ready=1, the next window starts clean.
REQ-043 rst pulse mid-SCAN, then 16 samples of class 0 -> no verdict for the aborted window; the next verdict is out_class=0, out_count=16.
REQ-044 WINDOW=2; samples 3, then 1 -> out_class=1, out_count=1, out_tie=1.

Source files
------------

// File: rtl/dtc_vote_accum.sv
// Majority vote over a window of decision-tree classifier results: counts each
// 3-bit class, scans the eight counters for the winner, then holds the verdict.
module dtc_vote_accum #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             live;
    logic             in_fire;
    logic             out_fire;

    logic [CNT_W-1:0] cnt [8];
    logic [CNT_W-1:0] smp;
    logic [3:0]       step;
    logic [CNT_W-1:0] cand_cnt;
    logic [2:0]       cand_cls;
    logic [CNT_W-1:0] best_cnt;
    logic [2:0]       best_cls;
    logic             best_tie;

    // live holds in_ready low during reset and until the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            live  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = live;
                if (in_valid && live && (smp == LAST_SMP)) state_nxt = SCAN;
            end
            SCAN: begin
                if (step == 4'd8) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // The scan registers each counter into cand_* one beat before comparing it,
    // keeping the 8:1 counter mux and the magnitude compare in separate cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter bank is a handful of flops, not a RAM, so it is
            // reset; a stale window must never leak into the next verdict.
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            smp      <= '0;
            step     <= '0;
            cand_cnt <= '0;
            cand_cls <= '0;
            best_cnt <= '0;
            best_cls <= '0;
            best_tie <= 1'b0;
        end else if (out_fire) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            smp      <= '0;
            step     <= '0;
            cand_cnt <= '0;
            cand_cls <= '0;
            best_cnt <= '0;
            best_cls <= '0;
            best_tie <= 1'b0;
        end else begin
            if (in_fire) begin
                cnt[in_class] <= cnt[in_class] + CNT_ONE;
                smp           <= smp + CNT_ONE;
                if (smp == LAST_SMP) step <= '0;
            end
            if (state == SCAN) begin
                step <= step + 4'd1;
                if (step < 4'd8) begin
                    cand_cnt <= cnt[step[2:0]];
                    cand_cls <= step[2:0];
                end
                if (step == 4'd1) begin
                    best_cnt <= cand_cnt;
                    best_cls <= cand_cls;
                    best_tie <= 1'b0;
                end else if (step != 4'd0) begin
                    // Strictly-greater update: the lowest class index wins ties.
                    if (cand_cnt > best_cnt) begin
                        best_cnt <= cand_cnt;
                        best_cls <= cand_cls;
                        best_tie <= 1'b0;
                    end else if (cand_cnt == best_cnt) begin
                        best_tie <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_class = best_cls;
    assign out_count = best_cnt;
    assign out_tie   = best_tie;

endmodule
